// File: rtl/relogio_display_scan_if.sv
// Time-in / display-out bundle for the HH.MM.SS scanner.
// Pins are in their physical polarity.
interface relogio_display_scan_if;
  logic [4:0] horas;
  logic [5:0] minutos;
  logic [5:0] segundos;
  logic [5:0] an;
  logic [6:0] seg;
  logic       dp;
  logic       frame_tick;

  modport master (
    output horas,
    output minutos,
    output segundos,
    input  an,
    input  seg,
    input  dp,
    input  frame_tick
  );

  modport slave (
    input  horas,
    input  minutos,
    input  segundos,
    output an,
    output seg,
    output dp,
    output frame_tick
  );
endinterface

// File: rtl/relogio_display_scan.sv
// 6-digit multiplexed 7-segment scanner for HH.MM.SS.
// Time is snapshotted once per frame so a frame never tears.
module relogio_display_scan #(
  parameter int SCAN_DIV   = 1000,
  parameter int BLANK_CYC  = 2,
  parameter bit ACTIVE_LOW = 1'b1
) (
  input logic             clk,
  input logic             rst,
  relogio_display_scan_if.slave bus
);

  localparam logic [15:0] LAST = 16'(SCAN_DIV - 1);

  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  digit_q, digit_d;
  logic [4:0]  snap_h_q, snap_h_d;
  logic [5:0]  snap_m_q, snap_m_d;
  logic [5:0]  snap_s_q, snap_s_d;
  logic        tick_q, tick_d;
  logic [5:0]  an_q, an_d;
  logic [6:0]  seg_q, seg_d;
  logic        dp_q, dp_d;

  logic        wrap;
  logic        frame;
  logic        blank;
  logic [7:0]  bcd_h, bcd_m, bcd_s;
  logic        bad_h, bad_m, bad_s;
  logic [3:0]  nib;
  logic        dash;

  // Repeated subtract-10 keeps this divider-free.
  function automatic logic [7:0] to_bcd(input logic [5:0] v);
    logic [5:0] r;
    logic [3:0] t;
    r = v;
    t = 4'd0;
    for (int i = 0; i < 6; i++) begin
      if (r >= 6'd10) begin
        r = r - 6'd10;
        t = t + 4'd1;
      end
    end
    return {t, r[3:0]};
  endfunction

  function automatic logic [6:0] seg_of(input logic [3:0] d);
    logic [6:0] s;
    unique case (d)
      4'd0:    s = 7'h3f;
      4'd1:    s = 7'h06;
      4'd2:    s = 7'h5b;
      4'd3:    s = 7'h4f;
      4'd4:    s = 7'h66;
      4'd5:    s = 7'h6d;
      4'd6:    s = 7'h7d;
      4'd7:    s = 7'h07;
      4'd8:    s = 7'h7f;
      4'd9:    s = 7'h6f;
      default: s = 7'h40;
    endcase
    return s;
  endfunction

  generate
    if (BLANK_CYC == 0) begin : g_noblank
      assign blank = 1'b0;
    end else begin : g_blank
      assign blank = cnt_q < 16'(BLANK_CYC);
    end
  endgenerate

  assign bcd_h = to_bcd({1'b0, snap_h_q});
  assign bcd_m = to_bcd(snap_m_q);
  assign bcd_s = to_bcd(snap_s_q);
  assign bad_h = snap_h_q > 5'd23;
  assign bad_m = snap_m_q > 6'd59;
  assign bad_s = snap_s_q > 6'd59;

  always_comb begin
    cnt_d    = cnt_q + 16'd1;
    digit_d  = digit_q;
    snap_h_d = snap_h_q;
    snap_m_d = snap_m_q;
    snap_s_d = snap_s_q;
    an_d     = 6'd0;
    seg_d    = 7'd0;
    dp_d     = 1'b0;
    nib      = 4'd0;
    dash     = 1'b0;

    wrap  = cnt_q == LAST;
    frame = wrap && (digit_q == 3'd5);

    if (wrap) begin
      cnt_d   = 16'd0;
      digit_d = (digit_q == 3'd5) ? 3'd0 : digit_q + 3'd1;
    end
    if (frame) begin
      snap_h_d = bus.horas;
      snap_m_d = bus.minutos;
      snap_s_d = bus.segundos;
    end
    tick_d = frame;

    unique case (digit_q)
      3'd0: begin nib = bcd_h[7:4]; dash = bad_h; end
      3'd1: begin nib = bcd_h[3:0]; dash = bad_h; end
      3'd2: begin nib = bcd_m[7:4]; dash = bad_m; end
      3'd3: begin nib = bcd_m[3:0]; dash = bad_m; end
      3'd4: begin nib = bcd_s[7:4]; dash = bad_s; end
      default: begin nib = bcd_s[3:0]; dash = bad_s; end
    endcase

    if (!blank) begin
      an_d  = 6'b100000 >> digit_q;
      seg_d = dash ? 7'h40 : seg_of(nib);
      dp_d  = (digit_q == 3'd1) || (digit_q == 3'd3);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q    <= 16'd0;
      digit_q  <= 3'd0;
      snap_h_q <= 5'd0;
      snap_m_q <= 6'd0;
      snap_s_q <= 6'd0;
      tick_q   <= 1'b0;
      an_q     <= 6'd0;
      seg_q    <= 7'd0;
      dp_q     <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      digit_q  <= digit_d;
      snap_h_q <= snap_h_d;
      snap_m_q <= snap_m_d;
      snap_s_q <= snap_s_d;
      tick_q   <= tick_d;
      an_q     <= an_d;
      seg_q    <= seg_d;
      dp_q     <= dp_d;
    end
  end

  assign bus.an         = ACTIVE_LOW ? ~an_q  : an_q;
  assign bus.seg        = ACTIVE_LOW ? ~seg_q : seg_q;
  assign bus.dp         = ACTIVE_LOW ? ~dp_q  : dp_q;
  assign bus.frame_tick = tick_q;

endmodule

// File: tb/tb_relogio_display_scan.sv
// Scoreboard bench: two scanner configs driven by one time source.
// A cycle-count reference model feeds expected pin values to a monitor.
module tb_relogio_display_scan;

  localparam int N = 4;
  localparam int FRAME = 6 * N;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [4:0] h = 5'd13;
  logic [5:0] m = 6'd45;
  logic [5:0] s = 6'd7;

  always #5 clk = ~clk;

  relogio_display_scan_if ifa ();
  relogio_display_scan_if ifb ();

  assign ifa.horas    = h;
  assign ifa.minutos  = m;
  assign ifa.segundos = s;
  assign ifb.horas    = h;
  assign ifb.minutos  = m;
  assign ifb.segundos = s;

  relogio_display_scan #(
    .SCAN_DIV(N), .BLANK_CYC(1), .ACTIVE_LOW(1'b0)
  ) dut_a (.clk(clk), .rst(rst), .bus(ifa));

  relogio_display_scan #(
    .SCAN_DIV(N), .BLANK_CYC(0), .ACTIVE_LOW(1'b1)
  ) dut_b (.clk(clk), .rst(rst), .bus(ifb));

  typedef struct {
    logic [5:0] an_a;
    logic [6:0] seg_a;
    logic       dp_a;
    logic [5:0] an_b;
    logic [6:0] seg_b;
    logic       dp_b;
    logic       tick;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int fails = 0;
  int k = 0;
  int sh = 0, sm = 0, ss = 0;
  logic [6:0] tbl [10] = '{7'h3f, 7'h06, 7'h5b, 7'h4f, 7'h66,
                           7'h6d, 7'h7d, 7'h07, 7'h7f, 7'h6f};

  // Logical {an,seg,dp} for pre-edge cycle index kk.
  function automatic logic [13:0] slot(int kk, int blank_cyc);
    int d, v, lim;
    logic [5:0] an;
    logic [6:0] sg;
    logic dp;
    if ((kk % N) < blank_cyc) return 14'd0;
    d = (kk / N) % 6;
    v = (d < 2) ? sh : (d < 4) ? sm : ss;
    lim = (d < 2) ? 23 : 59;
    an = 6'(1 << (5 - d));
    if (v > lim) sg = 7'h40;
    else sg = tbl[(d % 2 == 0) ? v / 10 : v % 10];
    dp = (d == 1) || (d == 3);
    return {an, sg, dp};
  endfunction

  always @(posedge clk) begin
    exp_t e;
    logic [13:0] va, vb;
    if (rst) begin
      k = 0;
      sh = 0; sm = 0; ss = 0;
      e = '{6'd0, 7'd0, 1'b0, 6'h3f, 7'h7f, 1'b1, 1'b0};
    end else begin
      va = slot(k, 1);
      vb = ~slot(k, 0);
      e.an_a = va[13:8]; e.seg_a = va[7:1]; e.dp_a = va[0];
      e.an_b = vb[13:8]; e.seg_b = vb[7:1]; e.dp_b = vb[0];
      e.tick = (k % FRAME) == FRAME - 1;
      if (e.tick) begin
        sh = int'(h); sm = int'(m); ss = int'(s);
      end
      k = k + 1;
    end
    q.push_back(e);
  end

  task automatic chk(string nm, logic [7:0] act, logic [7:0] want);
    checks++;
    if (act !== want) begin
      fails++;
      if (fails <= 30)
        $display("FAIL %s got=%h want=%h t=%0t", nm, act, want, $time);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("an_a",   {2'b0, ifa.an},  {2'b0, e.an_a});
      chk("seg_a",  {1'b0, ifa.seg}, {1'b0, e.seg_a});
      chk("dp_a",   {7'b0, ifa.dp},  {7'b0, e.dp_a});
      chk("tick_a", {7'b0, ifa.frame_tick}, {7'b0, e.tick});
      chk("an_b",   {2'b0, ifb.an},  {2'b0, e.an_b});
      chk("seg_b",  {1'b0, ifb.seg}, {1'b0, e.seg_b});
      chk("dp_b",   {7'b0, ifb.dp},  {7'b0, e.dp_b});
      chk("tick_b", {7'b0, ifb.frame_tick}, {7'b0, e.tick});
    end
  end

  task automatic cycles(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_phase(int p);
    int n = 0;
    while ((k % FRAME) != p && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      checks++;
      fails++;
      $display("FAIL wait_phase timeout phase=%0d", p);
    end
  endtask

  initial begin
    cycles(3);
    rst = 1'b0;
    cycles(2 * FRAME + 4);

    h = 5'd12; m = 6'd59; s = 6'd30;
    wait_phase(0);
    wait_phase(9);
    m = 6'd0;
    cycles(2 * FRAME);

    h = 5'd24; m = 6'd60; s = 6'd23;
    cycles(2 * FRAME);

    h = 5'd23; m = 6'd59; s = 6'd59;
    cycles(FRAME + 3);
    wait_phase(6);
    rst = 1'b1;
    cycles(1);
    rst = 1'b0;
    cycles(FRAME + 5);

    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        h = 5'($urandom_range(0, 31));
        m = 6'($urandom_range(0, 63));
        s = 6'($urandom_range(0, 63));
      end
      rst = ($urandom_range(0, 149) == 0);
      cycles(1);
    end
    rst = 1'b0;
    cycles(FRAME);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule

// File: doc/relogio_display_scan.md
Name: relogio_display_scan

Overview:
- Downstream consumer of the h/m/s time counter.
- Takes binary hours/minutes/seconds and drives a 6-digit multiplexed 7-segment display showing HH.MM.SS.
- Samples the time once per scan frame so a single frame never mixes old and new values.
- Adds inter-digit blanking against ghosting and range-checks each field.

Parameters:
SCAN_DIV, 1000, clk cycles per digit slot; legal range 2..65535.
BLANK_CYC, 2, cycles at start of each slot with all anodes off; legal range 0..SCAN_DIV-1.
ACTIVE_LOW, 1, 1 = an/seg/dp driven active-low at the pins; 0 = active-high.

Ports:
clk  input  1  system clock, rising-edge.
rst  input  1  synchronous active-high reset.
horas  input  5  binary hours from time counter, legal 0..23.
minutos  input  6  binary minutes, legal 0..59.
segundos  input  6  binary seconds, legal 0..59.
an  output  6  digit enables; bit 5 = leftmost (hours tens), bit 0 = seconds units.
seg  output  7  segments {g,f,e,d,c,b,a}.
dp  output  1  decimal point, used as separator.
frame_tick  output  1  one-cycle pulse when a new snapshot is taken.

Behaviour:
- All outputs below are given in logical polarity (1 = lit/enabled). When ACTIVE_LOW=1, an, seg and dp are inverted at the pins; frame_tick is never inverted.
- Reset (rst=1 on a rising edge):
  - cnt=0, digit=0, snapshot h/m/s=0.
  - an=0, seg=0, dp=0, frame_tick=0.
  - rst mid-frame aborts the scan immediately; the next cycle restarts at digit 0, cnt 0.
- Slot divider:
  - cnt counts 0..SCAN_DIV-1.
  - At cnt==SCAN_DIV-1: cnt->0 and digit advances 0,1,2,3,4,5,0.
- Snapshot:
  - Loaded from horas/minutos/segundos on the cycle where cnt==SCAN_DIV-1 and digit==5, i.e. at the frame wrap.
  - frame_tick=1 on the following cycle only.
  - Inputs are ignored at all other times.
- Digit mapping:
  - digit 0 = hours tens, 1 = hours units, 2 = min tens, 3 = min units, 4 = sec tens, 5 = sec units.
  - digit d drives an bit (5-d).
- BCD conversion: tens = v/10, units = v%10, combinational on the snapshot. No divider IP; compare/subtract chain is acceptable.
- Range check: if snapshot hours>23, both hour digits show dash. Same for minutes>59 or seconds>59 on their pair. Fields are checked independently.
- Segment codes (hex):
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F, dash=40.
  - Leading zeros are displayed, not blanked.
- dp=1 while digit 1 or digit 3 is enabled; 0 otherwise.
- Output timing:
  - an, seg and dp are registered with exactly 1 cycle latency from (cnt, digit, snapshot).
  - Output in cycle t+1 reflects state in cycle t.
  - an is one-hot for the current digit when cnt>=BLANK_CYC; otherwise an=0 and seg=0, dp=0.
- BLANK_CYC=0: no blanking; an is never all-zero after the first post-reset cycle.
- Input changes mid-frame have no effect until the next frame wrap.
- No handshake with the counter. The counter may update at any time, including on the snapshot cycle: the value present on that edge is taken.

Test Plan:
- Reset: SCAN_DIV=4, BLANK_CYC=1, ACTIVE_LOW=0, hold rst 3 cycles -> an=0, seg=0, dp=0, frame_tick=0 every cycle while rst=1.
- First frame: release rst, inputs 13/45/07 -> first frame shows 00.00.00 (seg=3F on each lit slot). frame_tick fires 24 cycles after release. Second frame shows an=100000 seg=06, 010000 seg=4F dp=1, 001000 seg=66, 000100 seg=6D dp=1, 000010 seg=3F, 000001 seg=07.
- Blanking: SCAN_DIV=4, BLANK_CYC=1 -> each 4-cycle slot has exactly 1 output cycle with an=0, seg=0, then 3 cycles lit. With BLANK_CYC=0, an is nonzero every cycle after the first.
- Tearing: change minutos 59->00 while digit=2 is displayed -> the current frame still shows 5,9. The next frame shows 0,0. frame_tick pulses once per 6*SCAN_DIV cycles.
- Range check: horas=24, minutos=60, segundos=23 -> digits 0-3 seg=40, digit 4 seg=5B, digit 5 seg=4F.
- Polarity and reset: ACTIVE_LOW=1, display 23:59:59 -> pins show an=011111 with seg=24 (~5B&7F) on digit 0. Assert rst mid-slot -> next cycle an=111111 (all off), seg=7F, dp=1 (off); scan restarts at digit 0.
